// File: rtl/serial_nibble_subtractor.sv
// ============================================================================
// serial_nibble_subtractor : DIFF = A - B - bi, one SLICE-bit slice per clock
// Optional macro SUB_ZERO_FLAG_EN adds the 'zero' result flag.   Rev 1.0
// ============================================================================
`default_nettype none

module serial_nibble_subtractor #(
  parameter int N     = 24,
  parameter int SLICE = 4
) (
  input  logic         CK,
  input  logic         RN,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         bi,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] DIFF,
  output logic         bo,
`ifdef SUB_ZERO_FLAG_EN
  output logic         zero,
`endif
  output logic         ovf
);

  localparam int NSL = N / SLICE;
  localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NSL - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic            brw_q;
  logic [KW-1:0]   k_q;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE:0]  slice_res;
  logic            slice_zero;
  logic            ovf_next;
`ifdef SUB_ZERO_FLAG_EN
  logic            zacc_q;
`endif

  // Bit SLICE of the (SLICE+1)-bit difference is the borrow out of this slice.
  always_comb begin
    a_sl       = a_q[k_q*SLICE +: SLICE];
    b_sl       = b_q[k_q*SLICE +: SLICE];
    slice_res  = {1'b0, a_sl} - {1'b0, b_sl} - {{SLICE{1'b0}}, brw_q};
    slice_zero = ~|slice_res[SLICE-1:0];
    ovf_next   = (a_q[N-1] != b_q[N-1]) && (slice_res[SLICE-1] != a_q[N-1]);
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      brw_q <= 1'b0;
      k_q   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      DIFF  <= '0;
      bo    <= 1'b0;
      ovf   <= 1'b0;
`ifdef SUB_ZERO_FLAG_EN
      zacc_q <= 1'b0;
      zero   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            brw_q <= bi;
            k_q   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
`ifdef SUB_ZERO_FLAG_EN
            zacc_q <= 1'b1;
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          DIFF[k_q*SLICE +: SLICE] <= slice_res[SLICE-1:0];
          brw_q <= slice_res[SLICE];
          k_q   <= k_q + KW'(1);
`ifdef SUB_ZERO_FLAG_EN
          zacc_q <= zacc_q & slice_zero;
`endif
          if (k_q == LAST_K) begin
            bo    <= slice_res[SLICE];
            ovf   <= ovf_next;
            k_q   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
`ifdef SUB_ZERO_FLAG_EN
            zero  <= zacc_q & slice_zero;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef SUB_ZERO_FLAG_EN
  logic unused_ok;
  assign unused_ok = slice_zero;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_nibble_subtractor.sv
// ============================================================================
// tb_serial_nibble_subtractor : directed + random checks against an
// arithmetic reference model (honours SUB_ZERO_FLAG_EN).          Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_nibble_subtractor;
  localparam int N = 24;

  logic         CK = 1'b0;
  logic         RN = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         bi = 1'b0;
  logic         busy, done, bo, ovf;
  logic [N-1:0] DIFF;
`ifdef SUB_ZERO_FLAG_EN
  logic         zero;
`endif

  int compared   = 0;
  int mismatched = 0;

  serial_nibble_subtractor #(.N(N), .SLICE(4)) dut (
    .CK   (CK),
    .RN   (RN),
    .start(start),
    .A    (A),
    .B    (B),
    .bi   (bi),
    .busy (busy),
    .done (done),
    .DIFF (DIFF),
    .bo   (bo),
`ifdef SUB_ZERO_FLAG_EN
    .zero (zero),
`endif
    .ovf  (ovf)
  );

  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_diff"}, 32'(DIFF), 32'd0);
    chk({tag, "_bo"},   32'(bo),   32'd0);
    chk({tag, "_ovf"},  32'(ovf),  32'd0);
`ifdef SUB_ZERO_FLAG_EN
    chk({tag, "_zero"}, 32'(zero), 32'd0);
`endif
  endtask

  // Reference: plain integer arithmetic modulo 2^N.
  task automatic chk_result(input string tag, input logic [N-1:0] a,
                            input logic [N-1:0] b, input logic c);
    longint ua, ub, d;
    logic [N-1:0] ed;
    logic eb, eo;
    ua = longint'(a);
    ub = longint'(b);
    d  = ua - ub - longint'(c);
    eb = (d < 0);
    if (d < 0) d = d + (longint'(1) << N);
    ed = N'(d);
    eo = (a[N-1] != b[N-1]) && (ed[N-1] != a[N-1]);
    chk({tag, "_diff"}, 32'(DIFF), 32'(ed));
    chk({tag, "_bo"},   32'(bo),   32'(eb));
    chk({tag, "_ovf"},  32'(ovf),  32'(eo));
`ifdef SUB_ZERO_FLAG_EN
    chk({tag, "_zero"}, 32'(zero), 32'(ed == '0));
`endif
  endtask

  // Drives a start, waits (bounded) for done, checks latency and the result.
  // With hold=1, start stays high and the operand inputs are scrambled during RUN.
  task automatic op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                    input logic c, input bit hold);
    int lat;
    A = a; B = b; bi = c; start = 1'b1;
    @(posedge CK); #1;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    if (!hold) start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (hold) begin
        A = N'($urandom); B = N'($urandom); bi = 1'($urandom);
      end
      @(posedge CK); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'd6);
    chk_result(tag, a, b, c);
  endtask

  initial begin
    logic [N-1:0] ra, rb, held;

    #12;
    chk_cleared("reset");
    @(negedge CK); RN = 1'b1;
    @(negedge CK);

    op("basic",     24'h000005, 24'h000003, 1'b0, 1'b0);
    @(posedge CK); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("diff_held", 32'(DIFF), 32'h000002);

    op("underflow", 24'h000000, 24'h000001, 1'b0, 1'b0);
    op("sovf",      24'h800000, 24'h000001, 1'b0, 1'b0);
    op("borrow_in", 24'h100000, 24'h0FFFFF, 1'b1, 1'b0);
    op("eq_bi",     24'h3A5C7E, 24'h3A5C7E, 1'b1, 1'b0);

    // Start held through RUN with changing inputs.
    op("hold",      24'h123456, 24'h654321, 1'b0, 1'b1);

    // Back-to-back: start asserted during the DONE cycle.
    op("b2b_first", 24'h00000A, 24'h000001, 1'b0, 1'b0);
    op("b2b_second", 24'h000007, 24'h000002, 1'b0, 1'b0);
    held = DIFF;
    @(posedge CK); #1;
    chk("b2b_idle_diff", 32'(DIFF), 32'(held));

    for (int i = 0; i < 24; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      if (i % 6 == 0) rb = ra;
      op("rand", ra, rb, 1'($urandom), bit'($urandom_range(0, 1)));
    end

    // Asynchronous abort mid-RUN.
    @(negedge CK);
    A = 24'hFFFFFF; B = 24'h000001; bi = 1'b0; start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    repeat (3) @(posedge CK);
    #2 RN = 1'b0;
    #1;
    chk_cleared("abort");
    @(negedge CK); RN = 1'b1;
    @(negedge CK);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    op("after_abort", 24'h000009, 24'h000004, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/serial_nibble_subtractor.md
Name: serial_nibble_subtractor

Overview:
- Multi-cycle two's-complement subtractor: DIFF = A - B - bi, computed one SLICE-bit slice per clock, LSB slice first.
- Borrow is registered between slices.
- Inverse-direction companion to the combinational ripple-adder datapath; used where area beats latency.
- Start/busy/done handshake; operands are captured on start, results are held until the next accepted start.

Parameters:
- N, 24, operand and result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; NSL = N/SLICE slices.

Ports:
- CK  input  1  clock, rising edge.
- RN  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only when busy=0.
- A  input  N  minuend, sampled on accepted start.
- B  input  N  subtrahend, sampled on accepted start.
- bi  input  1  borrow-in, sampled on accepted start.
- busy  output  1  high while slices are being computed.
- done  output  1  one-cycle pulse when DIFF/bo/ovf become valid.
- DIFF  output  N  difference.
- bo  output  1  borrow-out from the MSB slice (1 = unsigned A < B+bi).
- ovf  output  1  signed overflow.

Behaviour:
- Reset: RN low asynchronously clears all state. Outputs: busy=0, done=0, DIFF=0, bo=0, ovf=0; state=IDLE; slice index=0.
- States:
  - IDLE: start=1 -> latch A, B, bi; slice index=0; borrow reg=bi; go to RUN, busy=1 next cycle.
  - RUN: each cycle computes slice k: {b_out, d} = A[k] - B[k] - borrow (SLICE+1-bit arithmetic), writes d into DIFF[k*SLICE +: SLICE], sets borrow reg=b_out, increments k.
    - When k = NSL-1: also load bo=b_out and ovf, then go to DONE.
  - DONE: done=1 and busy=0 for exactly this cycle, then go to IDLE. start=1 in DONE is accepted exactly as in IDLE (back-to-back; done still pulses this cycle).
- Latency: start sampled at edge 0 -> done high during cycle after edge NSL (6 for default N=24). Throughput is one result per NSL+1 cycles.
- ovf = (A[N-1] != B[N-1]) && (DIFF[N-1] != A[N-1]), using the latched operands.
- bi participates only as the initial borrow of slice 0. bi=1 with A=B gives DIFF=all-ones, bo=1.
- start while busy=1 is ignored; latched operands and progress are unaffected.
- DIFF is updated slice by slice during RUN; it is valid only from done onward and is held stable until the next accepted start completes its first slice.
- Input changes on A/B/bi after acceptance have no effect.
- RN asserted mid-operation aborts; after release the block is IDLE with zeroed outputs, and the aborted result is lost.
- Wrap-around: results are modulo 2^N; there is no saturation.

Optional Feature:
- Macro SUB_ZERO_FLAG_EN.
- Defined: adds output port zero (1 bit).
  - Reset value 0.
  - Loaded with 1 when the final DIFF equals 0; valid from done; held until the next done.
  - Computed incrementally: an AND of per-slice zero bits, accumulated during RUN.
- Undefined: port absent; no extra logic.

Test Plan:
- Basic subtract: A=0x000005, B=0x000003, bi=0, start pulse -> done exactly 6 cycles later; DIFF=0x000002, bo=0, ovf=0 (zero=0 if enabled).
- Unsigned underflow: A=0x000000, B=0x000001, bi=0 -> DIFF=0xFFFFFF, bo=1, ovf=0.
- Signed overflow: A=0x800000, B=0x000001, bi=0 -> DIFF=0x7FFFFF, bo=0, ovf=1.
- Borrow-in across slices: A=0x100000, B=0x0FFFFF, bi=1 -> DIFF=0x000000, bo=0, ovf=0, zero=1 if SUB_ZERO_FLAG_EN.
- Handshake:
  - start held high throughout a RUN with changing A/B -> result matches the operands latched at acceptance.
  - start=1 in the DONE cycle with A=7, B=2 -> second done 7 cycles after the first; DIFF=0x000005.
- Reset abort: RN low at cycle 3 of RUN -> busy, done, DIFF, bo and ovf all 0 immediately (asynchronous). After RN high, a new start with A=9, B=4 -> DIFF=0x000005 after 6 cycles.
